// File: rtl/fft_iter_scheduler.sv
// Address/strobe sequencer for an iterative in-place radix-2 FFT: walks L stages of
// N/2 butterflies, drains the butterfly pipeline between stages, replays addresses as write-backs.
module fft_iter_scheduler #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned BF_LATENCY = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  START,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_RD_EN,
  output logic [ADDR_WIDTH-1:0] o_RD_ADDR_A,
  output logic [ADDR_WIDTH-1:0] o_RD_ADDR_B,
  output logic [ADDR_WIDTH-2:0] o_TW_ADDR,
  output logic                  o_WR_EN,
  output logic [ADDR_WIDTH-1:0] o_WR_ADDR_A,
  output logic [ADDR_WIDTH-1:0] o_WR_ADDR_B,
  output logic [ADDR_WIDTH-1:0] o_STAGE
);

  localparam int unsigned L  = ADDR_WIDTH;
  localparam int unsigned JW = L - 1;
  localparam int unsigned SW = $clog2(L);
  localparam int unsigned DW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(L - 1);
  localparam logic [DW-1:0] D_LAST = DW'(BF_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [SW-1:0] s;
  logic [JW-1:0] j;
  logic [DW-1:0] d;
  logic [L-1:0]  stage;

  logic [L-1:0]  dl_a [BF_LATENCY];
  logic [L-1:0]  dl_b [BF_LATENCY];
  logic          dl_v [BF_LATENCY];

  logic          rd_en;
  logic [L-1:0]  span;
  logic [L-1:0]  mask;
  logic [L-1:0]  addr_a;
  logic [L-1:0]  addr_b;
  logic [JW-1:0] tw;

  // Stage/butterfly sequencing; EN low freezes every register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      s     <= '0;
      j     <= '0;
      d     <= '0;
      stage <= L'(1);
    end else if (EN) begin
      case (state)
        IDLE: begin
          if (START) begin
            state <= RUN;
            s     <= '0;
            j     <= '0;
          end
        end
        RUN: begin
          if (j == J_LAST) begin
            state <= DRAIN;
            d     <= '0;
          end else begin
            j <= j + JW'(1);
          end
        end
        DRAIN: begin
          if (d == D_LAST) begin
            if (s == S_LAST) begin
              state <= DONE;
            end else begin
              state <= RUN;
              s     <= s + SW'(1);
              j     <= '0;
              stage <= {stage[L-2:0], stage[L-1]};
            end
          end else begin
            d <= d + DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          stage <= {stage[L-2:0], stage[L-1]};
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Insert a zero at bit s of j for leg A; leg B sets that bit
  always_comb begin
    span   = L'(1) << s;
    mask   = span - L'(1);
    addr_a = (((L'(j) >> s) << s) << 1) | (L'(j) & mask);
    addr_b = addr_a | span;
    tw     = (j & JW'(mask)) << (JW - s);
  end

  assign rd_en       = EN && (state == RUN);
  assign o_RD_EN     = rd_en;
  assign o_RD_ADDR_A = rd_en ? addr_a : '0;
  assign o_RD_ADDR_B = rd_en ? addr_b : '0;
  assign o_TW_ADDR   = rd_en ? tw : '0;
  assign o_BUSY      = (state == RUN) || (state == DRAIN);
  assign o_DONE      = (state == DONE);
  assign o_STAGE     = stage;

  // Write-back delay line; cleared on reset so in-flight butterflies never write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(BF_LATENCY); i++) begin
        dl_v[i] <= 1'b0;
        dl_a[i] <= '0;
        dl_b[i] <= '0;
      end
    end else if (EN) begin
      dl_v[0] <= rd_en;
      dl_a[0] <= o_RD_ADDR_A;
      dl_b[0] <= o_RD_ADDR_B;
      for (int i = 1; i < int'(BF_LATENCY); i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
        dl_b[i] <= dl_b[i-1];
      end
    end
  end

  assign o_WR_EN     = EN && dl_v[BF_LATENCY-1];
  assign o_WR_ADDR_A = o_WR_EN ? dl_a[BF_LATENCY-1] : '0;
  assign o_WR_ADDR_B = o_WR_EN ? dl_b[BF_LATENCY-1] : '0;

endmodule

// File: tb/tb_fft_iter_scheduler.sv
// Scoreboard bench for fft_iter_scheduler: expected reads, write-backs and done pulses are
// queued when a run starts; a negedge monitor pops and compares whenever the DUT strobes.
module tb_fft_iter_scheduler;

  localparam int unsigned AW = 4;
  localparam int unsigned BL = 3;
  localparam int LL = AW;
  localparam int HALF = 1 << (AW - 1);
  localparam int STAGE_LEN = HALF + BL;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN = 1'b1;
  logic          START = 1'b0;
  logic          o_BUSY, o_DONE, o_RD_EN, o_WR_EN;
  logic [AW-1:0] o_RD_ADDR_A, o_RD_ADDR_B, o_WR_ADDR_A, o_WR_ADDR_B, o_STAGE;
  logic [AW-2:0] o_TW_ADDR;

  fft_iter_scheduler #(.ADDR_WIDTH(AW), .BF_LATENCY(BL)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START),
    .o_BUSY(o_BUSY), .o_DONE(o_DONE),
    .o_RD_EN(o_RD_EN), .o_RD_ADDR_A(o_RD_ADDR_A), .o_RD_ADDR_B(o_RD_ADDR_B),
    .o_TW_ADDR(o_TW_ADDR),
    .o_WR_EN(o_WR_EN), .o_WR_ADDR_A(o_WR_ADDR_A), .o_WR_ADDR_B(o_WR_ADDR_B),
    .o_STAGE(o_STAGE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int s;
    int j;
    int a;
    int b;
    int tw;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];

  int nchk = 0;
  int nerr = 0;

  // Hand-computed address vectors: s, j, A, B, TW
  int spot [4][5] = '{'{0, 0, 0, 1, 0}, '{1, 1, 1, 3, 4}, '{2, 6, 10, 14, 4}, '{3, 5, 5, 13, 5}};

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: build A bit by bit, skipping position s
  task automatic model(input int s, input int j, output int a, output int b, output int tw);
    int src;
    a = 0;
    src = 0;
    for (int bp = 0; bp < LL; bp++) begin
      if (bp != s) begin
        a = a | (((j >> src) & 1) << bp);
        src++;
      end
    end
    b  = a + (1 << s);
    tw = ((j % (1 << s)) * (1 << (LL - 1 - s))) % HALF;
  endtask

  // Unstalled time r shifts by 5 for every 5-cycle stall starting at or before r
  function automatic int shifted(input int r, input int p1, input int p2);
    int v;
    v = r;
    if (p1 >= 0 && r >= p1) v += 5;
    if (p2 >= 0 && r >= p2) v += 5;
    return v;
  endfunction

  task automatic push_run(input int k, input int p1, input int p2);
    ev_t e;
    for (int s = 0; s < LL; s++) begin
      for (int j = 0; j < HALF; j++) begin
        e.s = s;
        e.j = j;
        model(s, j, e.a, e.b, e.tw);
        e.cyc = k + shifted(s * STAGE_LEN + j, p1, p2);
        rd_q.push_back(e);
        e.cyc = k + shifted(s * STAGE_LEN + j + int'(BL), p1, p2);
        wr_q.push_back(e);
      end
    end
    done_q.push_back(k + shifted(LL * STAGE_LEN, p1, p2));
  endtask

  task automatic wait_rel(input int k, input int r);
    while (cyc < k + r) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Pulse START; returns the edge count k of the sampling edge (first read seen while cyc==k)
  task automatic start_run(input int p1, input int p2, output int k);
    @(posedge CLK);
    #1 START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    k = cyc;
    push_run(k, p1, p2);
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((rd_q.size() + wr_q.size() + done_q.size()) != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    chk(nm, rd_q.size() + wr_q.size() + done_q.size(), 0);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // Monitor
  always @(negedge CLK) begin : mon
    ev_t e;
    if (!RST) begin
      if (o_BUSY && o_DONE) chk("busy_done_overlap", 1, 0);
      if (!EN) chk("stall_strobes", int'({o_RD_EN, o_WR_EN}), 0);
      if (o_RD_EN) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", int'(o_RD_ADDR_A), -1);
        end else begin
          e = rd_q.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_a", int'(o_RD_ADDR_A), e.a);
          chk("rd_b", int'(o_RD_ADDR_B), e.b);
          chk("rd_tw", int'(o_TW_ADDR), e.tw);
          chk("rd_stage", int'(o_STAGE), 1 << e.s);
          chk("rd_busy", int'(o_BUSY), 1);
          for (int i = 0; i < 4; i++) begin
            if (e.s == spot[i][0] && e.j == spot[i][1]) begin
              chk("spot_a", int'(o_RD_ADDR_A), spot[i][2]);
              chk("spot_b", int'(o_RD_ADDR_B), spot[i][3]);
              chk("spot_tw", int'(o_TW_ADDR), spot[i][4]);
            end
          end
        end
      end
      if (o_WR_EN) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", int'(o_WR_ADDR_A), -1);
        end else begin
          e = wr_q.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_a", int'(o_WR_ADDR_A), e.a);
          chk("wr_b", int'(o_WR_ADDR_B), e.b);
        end
      end
      if (o_DONE) begin
        if (done_q.size() == 0) chk("done_unexpected", cyc, -1);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_busy"}, int'(o_BUSY), 0);
    chk({nm, "_done"}, int'(o_DONE), 0);
    chk({nm, "_rd_en"}, int'(o_RD_EN), 0);
    chk({nm, "_wr_en"}, int'(o_WR_EN), 0);
    chk({nm, "_addrs"}, int'(o_RD_ADDR_A | o_RD_ADDR_B | o_WR_ADDR_A | o_WR_ADDR_B), 0);
    chk({nm, "_tw"}, int'(o_TW_ADDR), 0);
    chk({nm, "_stage"}, int'(o_STAGE), 1);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk_idle_outputs("reset");

    // Plain full run: 32 reads, 32 write-backs, done 44 edges after START edge
    start_run(-1, -1, k);
    drain("full_run_drain", 120);
    chk("full_run_stage_back", int'(o_STAGE), 1);

    // EN stalls: mid-RUN of stage 0 and mid-DRAIN of stage 1
    start_run(3, 20, k);
    wait_rel(k, 3);
    EN = 1'b0;
    wait_rel(k, 8);
    EN = 1'b1;
    wait_rel(k, 25);
    EN = 1'b0;
    wait_rel(k, 30);
    EN = 1'b1;
    drain("stall_run_drain", 150);

    // Async reset between edges in the middle of stage 2
    start_run(-1, -1, k);
    wait_rel(k, 25);
    #2 RST = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    chk_idle_outputs("post_rst");
    start_run(-1, -1, k);
    drain("rerun_drain", 120);

    // START pulses during RUN, DRAIN and DONE are ignored
    start_run(-1, -1, k);
    wait_rel(k, 4);
    START = 1'b1;
    wait_rel(k, 5);
    START = 1'b0;
    wait_rel(k, 9);
    START = 1'b1;
    wait_rel(k, 10);
    START = 1'b0;
    wait_rel(k, 44);
    chk("done_at_restart_pulse", int'(o_DONE), 1);
    START = 1'b1;
    wait_rel(k, 45);
    START = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("no_restart_busy", int'(o_BUSY), 0);
    chk("no_restart_queues", rd_q.size() + wr_q.size() + done_q.size(), 0);
    chk("final_stage", int'(o_STAGE), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
